// File: rtl/pixel_frame_loader_pkg.sv
// ---------------------------------------------------------------------------
// pixel_frame_loader_pkg
// Shared types and widths for the pixel frame loader.
//   pfl_state_e       : loader FSM states (FILL=0, FULL=1, STREAM=2)
//   FRAME_COUNT_WIDTH : width of the replayed-frame counter
//   CHECKSUM_WIDTH    : width of the optional per-frame pixel sum
//   pfl_sum_add       : modulo-2^CHECKSUM_WIDTH accumulate of one pixel
// ---------------------------------------------------------------------------
package pixel_frame_loader_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } pfl_state_e;

    localparam int FRAME_COUNT_WIDTH = 16;
    localparam int CHECKSUM_WIDTH    = 16;

    // Wrapping add; pixels wider than the sum are folded modulo 2^CHECKSUM_WIDTH.
    function automatic logic [CHECKSUM_WIDTH-1:0] pfl_sum_add(
        input logic [CHECKSUM_WIDTH-1:0] acc,
        input logic [CHECKSUM_WIDTH-1:0] pixel
    );
        return acc + pixel;
    endfunction

endpackage

// File: rtl/pfl_frame_ram.sv
// ---------------------------------------------------------------------------
// pfl_frame_ram
// Single-port-write / single-port-read synchronous RAM holding one frame.
// Read data is registered: data for rd_addr appears the cycle after rd_en.
// Contents are never cleared.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe
//   rd_addr  : read address
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module pfl_frame_ram #(
    parameter int ADDR_WIDTH  = 6,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [PIXEL_WIDTH-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [PIXEL_WIDTH-1:0] rd_data
);

    logic [PIXEL_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
    logic [PIXEL_WIDTH-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pixel_frame_loader.sv
// ---------------------------------------------------------------------------
// pixel_frame_loader
// Buffers one frame from a valid/ready pixel stream and, on start, replays it
// to the classifier as a gap-free burst of FRAME_PIXELS pixels.
// Optional feature macro: PIXEL_FRAME_LOADER_CHECKSUM_EN adds frame_sum.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   s_pixel/s_valid/s_ready/s_last : input pixel stream
//   start         : request replay of the stored frame (honoured in FULL only)
//   m_pixel/m_valid/m_last         : replayed pixel burst
//   frame_full    : complete frame stored, replay not yet started
//   busy          : replay in progress
//   err_short     : one-cycle pulse, frame ended early and was discarded
//   frame_count   : frames fully replayed since reset (wrapping)
//   frame_sum     : (macro only) modulo-2^16 sum of the current frame's pixels
// ---------------------------------------------------------------------------
module pixel_frame_loader
    import pixel_frame_loader_pkg::*;
#(
    parameter int FRAME_PIXELS = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int PIXEL_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PIXEL_WIDTH-1:0]       s_pixel,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_last,
    input  logic                         start,
    output logic [PIXEL_WIDTH-1:0]       m_pixel,
    output logic                         m_valid,
    output logic                         m_last,
    output logic                         frame_full,
    output logic                         busy,
    output logic                         err_short,
`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
    output logic [CHECKSUM_WIDTH-1:0]    frame_sum,
`endif
    output logic [FRAME_COUNT_WIDTH-1:0] frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);

    pfl_state_e                   state_r;
    logic [ADDR_WIDTH-1:0]        wr_addr_r;
    logic [ADDR_WIDTH-1:0]        rd_addr_r;
    logic                         rd_done_r;   // all FRAME_PIXELS reads issued
    logic                         rd_vld_r;    // RAM output holds a frame pixel
    logic                         rd_last_r;   // ... and it is the final one
    logic                         s_ready_r;
    logic [PIXEL_WIDTH-1:0]       m_pixel_r;
    logic                         m_valid_r;
    logic                         m_last_r;
    logic                         frame_full_r;
    logic                         busy_r;
    logic                         err_short_r;
    logic [FRAME_COUNT_WIDTH-1:0] frame_count_r;

    logic                         accept_s;
    logic                         wr_last_s;
    logic                         rd_en_s;
    logic [PIXEL_WIDTH-1:0]       rd_data_s;

    assign accept_s  = s_valid && s_ready_r && (state_r == FILL);
    assign wr_last_s = (wr_addr_r == LAST_ADDR);
    assign rd_en_s   = (state_r == STREAM) && !rd_done_r;

    pfl_frame_ram #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept_s),
        .wr_addr (wr_addr_r),
        .wr_data (s_pixel),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_r),
        .rd_data (rd_data_s)
    );

    // Loader FSM, address counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= FILL;
            wr_addr_r     <= ADDR_ZERO;
            rd_addr_r     <= ADDR_ZERO;
            rd_done_r     <= 1'b0;
            rd_vld_r      <= 1'b0;
            rd_last_r     <= 1'b0;
            s_ready_r     <= 1'b1;
            m_pixel_r     <= '0;
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
            frame_full_r  <= 1'b0;
            busy_r        <= 1'b0;
            err_short_r   <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            err_short_r <= 1'b0;
            // Two-stage read pipeline: RAM register, then output register.
            rd_vld_r    <= rd_en_s;
            rd_last_r   <= rd_en_s && (rd_addr_r == LAST_ADDR);
            m_valid_r   <= rd_vld_r;
            m_last_r    <= rd_last_r;
            if (rd_vld_r) begin
                m_pixel_r <= rd_data_s;
            end

            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        if (wr_last_s) begin
                            // s_last on the final pixel carries no extra meaning.
                            state_r      <= FULL;
                            wr_addr_r    <= ADDR_ZERO;
                            s_ready_r    <= 1'b0;
                            frame_full_r <= 1'b1;
                        end else if (s_last) begin
                            wr_addr_r   <= ADDR_ZERO;
                            err_short_r <= 1'b1;
                        end else begin
                            wr_addr_r <= wr_addr_r + ADDR_ONE;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        state_r      <= STREAM;
                        frame_full_r <= 1'b0;
                        busy_r       <= 1'b1;
                        rd_addr_r    <= ADDR_ZERO;
                        rd_done_r    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (rd_en_s) begin
                        if (rd_addr_r == LAST_ADDR) begin
                            rd_done_r <= 1'b1;
                        end else begin
                            rd_addr_r <= rd_addr_r + ADDR_ONE;
                        end
                    end
                    // Last pixel is on the output now; hand back to the source.
                    if (m_last_r) begin
                        state_r       <= FILL;
                        busy_r        <= 1'b0;
                        s_ready_r     <= 1'b1;
                        rd_addr_r     <= ADDR_ZERO;
                        rd_done_r     <= 1'b0;
                        frame_count_r <= frame_count_r + 16'd1;
                    end
                end
                default: begin
                    state_r      <= FILL;
                    wr_addr_r    <= ADDR_ZERO;
                    rd_addr_r    <= ADDR_ZERO;
                    rd_done_r    <= 1'b0;
                    s_ready_r    <= 1'b1;
                    frame_full_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_r;
    assign m_pixel     = m_pixel_r;
    assign m_valid     = m_valid_r;
    assign m_last      = m_last_r;
    assign frame_full  = frame_full_r;
    assign busy        = busy_r;
    assign err_short   = err_short_r;
    assign frame_count = frame_count_r;

`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] sum_r;

    // Running pixel sum: cleared on discard and on return to FILL, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= 16'd0;
        end else if (accept_s) begin
            if (!wr_last_s && s_last) begin
                sum_r <= 16'd0;
            end else begin
                sum_r <= pfl_sum_add(sum_r, CHECKSUM_WIDTH'(s_pixel));
            end
        end else if ((state_r == STREAM) && m_last_r) begin
            sum_r <= 16'd0;
        end
    end

    assign frame_sum = sum_r;
`endif

endmodule

// File: tb/tb_pixel_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_pixel_frame_loader
// Directed + randomized bench for pixel_frame_loader with FRAME_PIXELS=4.
// The reference model keeps the last completed frame as a queue of pixels and
// a replay counter; expected replay timing is start-edge + 2 cycles.
// ---------------------------------------------------------------------------
module tb_pixel_frame_loader;
    import pixel_frame_loader_pkg::*;

    localparam int FP = 4;
    localparam int AW = 2;
    localparam int PW = 8;

    typedef logic [PW-1:0] pix_q_t [$];

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] s_pixel;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic          start;
    logic [PW-1:0] m_pixel;
    logic          m_valid;
    logic          m_last;
    logic          frame_full;
    logic          busy;
    logic          err_short;
    logic [15:0]   frame_count;
`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
    logic [15:0]   frame_sum;
`endif

    int     checks = 0;
    int     errors = 0;
    int     exp_count = 0;   // model: frames fully replayed since reset
    pix_q_t stored;          // model: last complete frame
    pix_q_t px;

    always #5 clk = ~clk;

    pixel_frame_loader #(
        .FRAME_PIXELS (FP),
        .ADDR_WIDTH   (AW),
        .PIXEL_WIDTH  (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_pixel     (s_pixel),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .start       (start),
        .m_pixel     (m_pixel),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .frame_full  (frame_full),
        .busy        (busy),
        .err_short   (err_short),
`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
        .frame_sum   (frame_sum),
`endif
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
    function automatic int model_sum(input pix_q_t q);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return s % 65536;
    endfunction
`endif

    // Present pixels from a negedge; returns at the negedge after the last accept.
    task automatic fill(input pix_q_t p, input int last_idx, input int max_gap, input bit start_on_last);
        for (int i = 0; i < p.size(); i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) @(negedge clk);
            s_valid = 1'b1;
            s_pixel = p[i];
            s_last  = (i == last_idx);
            start   = start_on_last && (i == p.size() - 1);
            check("s_ready_fill", 32'(s_ready), 32'd1);
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            start   = 1'b0;
        end
    endtask

    // Checks after a complete frame has been loaded; updates the model.
    task automatic after_full(input pix_q_t p);
        stored = p;
        check("frame_full", 32'(frame_full), 32'd1);
        check("s_ready_full", 32'(s_ready), 32'd0);
        check("err_short_full", 32'(err_short), 32'd0);
`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
        check("frame_sum", 32'(frame_sum), 32'(model_sum(p)));
`endif
    endtask

    // Pulse start from FULL and check the burst; optional start re-pulse
    // at burst index mid_start, optional reset at burst index rst_at.
    task automatic replay(input int mid_start, input int rst_at);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        check("frame_full_drop", 32'(frame_full), 32'd0);
        check("m_valid_lat0", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("m_valid_lat1", 32'(m_valid), 32'd0);
        for (int k = 0; k < FP; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("m_valid", 32'(m_valid), 32'd1);
            check("m_pixel", 32'(m_pixel), 32'(stored[k]));
            check("m_last", 32'(m_last), 32'(k == FP - 1));
            check("busy", 32'(busy), 32'd1);
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_count = 0;
                check("rst_m_valid", 32'(m_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_s_ready", 32'(s_ready), 32'd1);
                check("rst_frame_count", 32'(frame_count), 32'(exp_count));
                return;
            end
            if (k == mid_start) start = 1'b1;
        end
        start = 1'b0;
        @(negedge clk);
        exp_count = (exp_count + 1) % 65536;
        check("end_m_valid", 32'(m_valid), 32'd0);
        check("end_m_last", 32'(m_last), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        check("end_s_ready", 32'(s_ready), 32'd1);
        check("frame_count", 32'(frame_count), 32'(exp_count));
`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
        check("frame_sum_clr", 32'(frame_sum), 32'd0);
`endif
        @(negedge clk);
        check("no_extra_valid", 32'(m_valid), 32'd0);
    endtask

    task automatic rand_frame(output pix_q_t p);
        p = {};
        for (int i = 0; i < FP; i++) p.push_back(PW'($urandom));
    endtask

    initial begin
        rst = 1'b1; s_pixel = '0; s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_pixel", 32'(m_pixel), 32'd0);
        check("rst_frame_full", 32'(frame_full), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_short", 32'(err_short), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);

        // Start while filling is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fill_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("fill_start_m_valid", 32'(m_valid), 32'd0);

        // Fill and replay.
        px = '{8'd10, 8'd20, 8'd30, 8'd40};
        fill(px, -1, 0, 1'b0);
        after_full(px);
        replay(-1, -1);

        // Short frame discarded, then a good frame.
        px = '{8'd5, 8'd6};
        fill(px, 1, 0, 1'b0);
        check("err_short_pulse", 32'(err_short), 32'd1);
        check("short_frame_full", 32'(frame_full), 32'd0);
`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
        check("short_frame_sum", 32'(frame_sum), 32'd0);
`endif
        @(negedge clk);
        check("err_short_once", 32'(err_short), 32'd0);
        px = '{8'd1, 8'd2, 8'd3, 8'd4};
        fill(px, -1, 0, 1'b0);
        after_full(px);
        replay(-1, -1);

        // Start on the final accept, backpressure in FULL, start during STREAM.
        rand_frame(px);
        fill(px, -1, 0, 1'b1);
        after_full(px);
        s_valid = 1'b1;
        s_pixel = 8'd99;
        for (int i = 0; i < 3; i++) begin
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        replay(1, -1);

        // Gapped random frames.
        for (int r = 0; r < 3; r++) begin
            rand_frame(px);
            fill(px, -1, 3, 1'b0);
            after_full(px);
            replay(-1, -1);
        end

        // Reset on the second replayed pixel, then recover.
        rand_frame(px);
        fill(px, -1, 0, 1'b0);
        after_full(px);
        replay(-1, 1);
        rand_frame(px);
        fill(px, -1, 1, 1'b0);
        after_full(px);
        replay(-1, -1);

`ifdef PIXEL_FRAME_LOADER_CHECKSUM_EN
        px = '{8'd255, 8'd255, 8'd255, 8'd255};
        fill(px, -1, 0, 1'b0);
        check("sum_1020", 32'(frame_sum), 32'd1020);
        after_full(px);
        replay(-1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
Single-frame pixel buffer sitting directly upstream of the transformer classifier's pixel_in/pixel_valid input. Accepts a frame of pixels from the external sensor/DMA side over a valid/ready stream and stores it in an on-chip frame RAM. When started, it replays the frame as a gap-free burst, one pixel per cycle, so the classifier never sees a stalled or partial frame. Reports frame status to the CPU side.

Parameters:
FRAME_PIXELS, 64, pixels per frame; must be at least 2.
ADDR_WIDTH, 6, frame RAM address width; 2**ADDR_WIDTH must be at least FRAME_PIXELS.
PIXEL_WIDTH, 8, bits per pixel.

Ports:
clk  in  1  clock
rst  in  1  reset
s_pixel  in  PIXEL_WIDTH  incoming pixel
s_valid  in  1  incoming pixel valid
s_ready  out  1  loader can accept a pixel
s_last  in  1  source marks final pixel of its frame
start  in  1  request replay of the stored frame
m_pixel  out  PIXEL_WIDTH  pixel to classifier
m_valid  out  1  m_pixel valid (drives classifier pixel_valid)
m_last  out  1  final replayed pixel
frame_full  out  1  complete frame stored, replay not yet started
busy  out  1  replay in progress
err_short  out  1  one-cycle pulse: frame ended early and was discarded
frame_count  out  16  frames fully replayed since reset, wraps at 16'hFFFF to 0

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. At reset: state FILL, write/read addresses 0, s_ready=1, m_valid=0, m_last=0, m_pixel=0, frame_full=0, busy=0, err_short=0, frame_count=0. RAM contents are not cleared.
- FILL state:
  - s_ready=1. Each cycle with s_valid&&s_ready writes s_pixel to mem[wr_addr] and increments wr_addr.
  - On the accept at wr_addr==FRAME_PIXELS-1: go to FULL and set wr_addr=0. s_ready is low from the next cycle.
  - s_last on that final accept is ignored.
  - s_last on an earlier accept: the pixel is written but the frame is discarded; wr_addr=0, err_short pulses for one cycle, state stays FILL.
  - start is ignored in FILL.
- FULL state:
  - frame_full=1, s_ready=0.
  - start sampled high: go to STREAM, issue read of address 0, frame_full drops next cycle, busy=1 from the next cycle.
- STREAM state:
  - One synchronous RAM read is issued per cycle, addresses 0..FRAME_PIXELS-1.
  - Read data is registered, so m_valid first rises 2 cycles after the edge that sampled start.
  - m_valid then stays high for exactly FRAME_PIXELS consecutive cycles, with m_pixel=mem[i] in order.
  - m_last is high together with the final m_valid.
  - start is ignored while busy; there is no downstream backpressure.
- End of replay: in the cycle after m_last, m_valid=0, m_last=0, busy=0, s_ready=1, state FILL, and frame_count increments by 1 (modulo 2^16).
- Single buffer: no pixel is accepted during FULL or STREAM.
- Reset mid-operation: all state returns to reset values on the next edge. m_valid deasserts immediately, the buffered frame is abandoned, and frame_count is not incremented.
- start and the final fill accept in the same cycle: start is ignored, because the state is still FILL.

Optional Feature:
- Macro PIXEL_FRAME_LOADER_CHECKSUM_EN.
- Defined: adds output frame_sum, 16 bits, unsigned modulo-2^16 sum of all pixels accepted into the current frame.
  - Accumulator clears at reset, on a discarded short frame, and on entry to FILL.
  - frame_sum holds its value through FULL and STREAM.
- Not defined: port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package pixel_frame_loader_pkg holds:
  - state enum FILL/FULL/STREAM (2-bit encoding 0/1/2);
  - FRAME_COUNT_WIDTH=16;
  - CHECKSUM_WIDTH=16.
- One sub-module, pfl_frame_ram: synchronous 1-write/1-read RAM, parameterised by ADDR_WIDTH and PIXEL_WIDTH, with registered read data.
- The FSM, address counters and output registers live in the top module.

Test Plan:
- Fill and replay (FRAME_PIXELS=4): send pixels 10,20,30,40 back-to-back, then pulse start -> frame_full=1 after the 4th accept; m_valid high for 4 cycles starting 2 cycles after start; m_pixel 10,20,30,40; m_last on 40; frame_count=1; s_ready=1 the cycle after.
- Short frame: send 5,6 with s_last on 6 -> err_short pulses once, frame_full stays 0; then send 1,2,3,4 and pulse start -> replay 1,2,3,4.
- Backpressure and ignored start: hold s_valid high with a 5th pixel after FULL, and pulse start during FILL and during STREAM -> 5th pixel not accepted (s_ready=0), no extra replays, exactly 4 m_valid cycles.
- Gapped input: fill 4 pixels with random s_valid gaps -> correct replay order and values.
- Reset mid-stream: assert rst on the 2nd m_valid cycle -> next cycle m_valid=0, busy=0, s_ready=1, frame_count=0.
- Checksum (macro defined): pixels 255,255,255,255 -> frame_sum=1020; pixels 8'hFF repeated 300 times (FRAME_PIXELS=300, ADDR_WIDTH=9) -> frame_sum=76500 mod 65536=10964.
